// File: rtl/glyph_rom_8x16_if.sv
// Address/data bundle between the text-layout logic and the glyph ROM.
// The layout logic drives char_code/row; the ROM returns one 8-pixel row.
interface glyph_rom_8x16_if;
    localparam int unsigned CODE_W = 8;
    localparam int unsigned ROW_W  = 4;
    localparam int unsigned PIX_W  = 8;

    logic [CODE_W-1:0] char_code;
    logic [ROW_W-1:0]  row;
    logic [PIX_W-1:0]  data;

    modport master (output char_code, output row, input data);
    modport slave  (input char_code, input row, output data);
endinterface

// File: rtl/glyph_rom_8x16.sv
// 8x16 character-generator ROM (IBM VGA CP437 bitmaps) for space, digits and A-Z.
// Returns one pixel row per lookup, bit 7 = leftmost pixel; optional output register.
module glyph_rom_8x16 #(
    parameter bit         REGISTERED = 1'b1,
    parameter logic [7:0] BLANK_ROW  = 8'h00
) (
    input  logic              clk_50mhz,
    input  logic              reset_n,
    glyph_rom_8x16_if.slave   bus
);
    localparam int unsigned PIX_W = 8;
    localparam int unsigned BMP_W = 10 * PIX_W;

    // Only rows 2..11 carry pixels (plus Q's tail on rows 12/13); MSB byte is row 2.
    function automatic logic [PIX_W-1:0] glyph(input logic [7:0] code, input logic [3:0] r);
        logic [BMP_W-1:0] bmp;
        logic             hit;
        bmp   = '0;
        hit   = 1'b1;
        glyph = 8'h00;
        case (code)
            8'h20: bmp = '0;
            8'h30: bmp = 80'h7C_C6_C6_CE_DE_F6_E6_C6_C6_7C;
            8'h31: bmp = 80'h18_38_78_18_18_18_18_18_18_7E;
            8'h32: bmp = 80'h7C_C6_06_0C_18_30_60_C0_C6_FE;
            8'h33: bmp = 80'h7C_C6_06_06_3C_06_06_06_C6_7C;
            8'h34: bmp = 80'h0C_1C_3C_6C_CC_FE_0C_0C_0C_1E;
            8'h35: bmp = 80'hFE_C0_C0_C0_FC_06_06_06_C6_7C;
            8'h36: bmp = 80'h38_60_C0_C0_FC_C6_C6_C6_C6_7C;
            8'h37: bmp = 80'hFE_C6_06_06_0C_18_30_30_30_30;
            8'h38: bmp = 80'h7C_C6_C6_C6_7C_C6_C6_C6_C6_7C;
            8'h39: bmp = 80'h7C_C6_C6_C6_7E_06_06_06_0C_78;
            8'h41: bmp = 80'h10_38_6C_C6_C6_FE_C6_C6_C6_C6;
            8'h42: bmp = 80'hFC_66_66_66_7C_66_66_66_66_FC;
            8'h43: bmp = 80'h3C_66_C2_C0_C0_C0_C0_C2_66_3C;
            8'h44: bmp = 80'hF8_6C_66_66_66_66_66_66_6C_F8;
            8'h45: bmp = 80'hFE_66_62_68_78_68_60_62_66_FE;
            8'h46: bmp = 80'hFE_66_62_68_78_68_60_60_60_F0;
            8'h47: bmp = 80'h3C_66_C2_C0_C0_DE_C6_C6_66_3A;
            8'h48: bmp = 80'hC6_C6_C6_C6_FE_C6_C6_C6_C6_C6;
            8'h49: bmp = 80'h3C_18_18_18_18_18_18_18_18_3C;
            8'h4A: bmp = 80'h1E_0C_0C_0C_0C_0C_CC_CC_CC_78;
            8'h4B: bmp = 80'hE6_66_66_6C_78_78_6C_66_66_E6;
            8'h4C: bmp = 80'hF0_60_60_60_60_60_60_62_66_FE;
            8'h4D: bmp = 80'hC6_EE_FE_FE_D6_C6_C6_C6_C6_C6;
            8'h4E: bmp = 80'hC6_E6_F6_FE_DE_CE_C6_C6_C6_C6;
            8'h4F: bmp = 80'h7C_C6_C6_C6_C6_C6_C6_C6_C6_7C;
            8'h50: bmp = 80'hFC_66_66_66_7C_60_60_60_60_F0;
            8'h51: bmp = 80'h7C_C6_C6_C6_C6_C6_C6_D6_DE_7C;
            8'h52: bmp = 80'hFC_66_66_66_7C_6C_66_66_66_E6;
            8'h53: bmp = 80'h7C_C6_C6_60_38_0C_06_C6_C6_7C;
            8'h54: bmp = 80'h7E_7E_5A_18_18_18_18_18_18_3C;
            8'h55: bmp = 80'hC6_C6_C6_C6_C6_C6_C6_C6_C6_7C;
            8'h56: bmp = 80'hC6_C6_C6_C6_C6_C6_C6_6C_38_10;
            8'h57: bmp = 80'hC6_C6_C6_C6_D6_D6_D6_FE_EE_6C;
            8'h58: bmp = 80'hC6_C6_6C_7C_38_38_7C_6C_C6_C6;
            8'h59: bmp = 80'h66_66_66_66_3C_18_18_18_18_3C;
            8'h5A: bmp = 80'hFE_C6_86_0C_18_30_60_C2_C6_FE;
            default: hit = 1'b0;
        endcase

        if (!hit) begin
            glyph = BLANK_ROW;
        end else begin
            case (r)
                4'd2:  glyph = bmp[79:72];
                4'd3:  glyph = bmp[71:64];
                4'd4:  glyph = bmp[63:56];
                4'd5:  glyph = bmp[55:48];
                4'd6:  glyph = bmp[47:40];
                4'd7:  glyph = bmp[39:32];
                4'd8:  glyph = bmp[31:24];
                4'd9:  glyph = bmp[23:16];
                4'd10: glyph = bmp[15:8];
                4'd11: glyph = bmp[7:0];
                4'd12: glyph = (code == 8'h51) ? 8'h0C : 8'h00;
                4'd13: glyph = (code == 8'h51) ? 8'h0E : 8'h00;
                default: glyph = 8'h00;
            endcase
        end
    endfunction

    logic [PIX_W-1:0] row_c;
    assign row_c = glyph(bus.char_code, bus.row);

    generate
        if (REGISTERED) begin : g_reg
            logic [PIX_W-1:0] data_q;

            // One-cycle lookup; reset clears the row immediately.
            always_ff @(posedge clk_50mhz or negedge reset_n) begin
                if (!reset_n) begin
                    data_q <= '0;
                end else begin
                    data_q <= row_c;
                end
            end

            assign bus.data = data_q;
        end else begin : g_comb
            logic unused_clk_rst;
            assign unused_clk_rst = clk_50mhz ^ reset_n;
            assign bus.data = row_c;
        end
    endgenerate
endmodule

// File: tb/tb_glyph_rom_8x16.sv
// Bench for glyph_rom_8x16: registered and combinational builds driven side by side.
module tb_glyph_rom_8x16;
    typedef struct {
        logic [7:0] code;
        logic [3:0] row;
        logic [7:0] exp;
    } vec_t;

    logic clk_50mhz = 1'b0;
    logic reset_n;
    always #10 clk_50mhz = ~clk_50mhz;

    glyph_rom_8x16_if bus_r ();
    glyph_rom_8x16_if bus_c ();

    glyph_rom_8x16 #(.REGISTERED(1'b1), .BLANK_ROW(8'h00)) dut_r (
        .clk_50mhz (clk_50mhz),
        .reset_n   (reset_n),
        .bus       (bus_r)
    );

    glyph_rom_8x16 #(.REGISTERED(1'b0), .BLANK_ROW(8'h00)) dut_c (
        .clk_50mhz (clk_50mhz),
        .reset_n   (reset_n),
        .bus       (bus_c)
    );

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    logic [7:0] a_rows    [16] = '{8'h00, 8'h00, 8'h10, 8'h38, 8'h6C, 8'hC6, 8'hC6, 8'hFE,
                                   8'hC6, 8'hC6, 8'hC6, 8'hC6, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] zero_rows [16] = '{8'h00, 8'h00, 8'h7C, 8'hC6, 8'hC6, 8'hCE, 8'hDE, 8'hF6,
                                   8'hE6, 8'hC6, 8'hC6, 8'h7C, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] one_rows  [10] = '{8'h18, 8'h38, 8'h78, 8'h18, 8'h18, 8'h18, 8'h18, 8'h18,
                                   8'h18, 8'h7E};
    logic [7:0] blank_codes [5] = '{8'h20, 8'h61, 8'h00, 8'hFF, 8'h5B};

    task automatic check(input string what, input logic [7:0] code, input logic [3:0] r,
                         input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s code=%02h row=%0d: got %02h expected %02h", what, code, r, act, exp);
        end
    endtask

    task automatic add(input logic [7:0] c, input logic [3:0] r, input logic [7:0] e);
        vec_t v;
        v.code = c;
        v.row  = r;
        v.exp  = e;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [7:0] c, input logic [3:0] r);
        bus_r.char_code = c;
        bus_r.row       = r;
        bus_c.char_code = c;
        bus_c.row       = r;
    endtask

    initial begin
        // Vector table
        for (int i = 0; i < 16; i++) add(8'h41, 4'(i), a_rows[i]);
        for (int i = 0; i < 16; i++) add(8'h30, 4'(i), zero_rows[i]);
        for (int i = 0; i < 10; i++) add(8'h31, 4'(i + 2), one_rows[i]);
        for (int k = 0; k < 5; k++)
            for (int i = 0; i < 16; i++) add(blank_codes[k], 4'(i), 8'h00);
        add(8'h51, 4'd12, 8'h0C);
        add(8'h51, 4'd13, 8'h0E);
        add(8'h51, 4'd11, 8'h7C);
        add(8'h51, 4'd14, 8'h00);
        add(8'h42, 4'd2,  8'hFC);
        add(8'h5A, 4'd4,  8'h86);
        add(8'h4D, 4'd5,  8'hFE);
        add(8'h39, 4'd11, 8'h78);
        add(8'h54, 4'd4,  8'h5A);
        add(8'h57, 4'd11, 8'h6C);
        add(8'h47, 4'd11, 8'h3A);
        add(8'h34, 4'd7,  8'hFE);
        add(8'h4A, 4'd8,  8'hCC);
        add(8'h41, 4'd12, 8'h00);
        add(8'h30, 4'd13, 8'h00);

        // Reset with no clock edges yet, then with clock running
        reset_n = 1'b0;
        drive(8'h41, 4'd4);
        #1;
        check("reset_async", 8'h41, 4'd4, bus_r.data, 8'h00);
        repeat (3) @(posedge clk_50mhz);
        #1;
        check("reset_hold", 8'h41, 4'd4, bus_r.data, 8'h00);
        check("comb_in_reset", 8'h41, 4'd4, bus_c.data, 8'h6C);
        @(negedge clk_50mhz);
        reset_n = 1'b1;
        #1;
        check("reset_release_pre_edge", 8'h41, 4'd4, bus_r.data, 8'h00);
        @(posedge clk_50mhz);
        #1;
        check("first_lookup", 8'h41, 4'd4, bus_r.data, 8'h6C);

        // Table sweep, one new address per cycle
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk_50mhz);
            drive(vecs[i].code, vecs[i].row);
            #1;
            check("comb", vecs[i].code, vecs[i].row, bus_c.data, vecs[i].exp);
            @(posedge clk_50mhz);
            #1;
            check("reg", vecs[i].code, vecs[i].row, bus_r.data, vecs[i].exp);
        end

        // Back-to-back: output lags address by exactly one edge
        @(negedge clk_50mhz);
        drive(8'h41, 4'd7);
        @(posedge clk_50mhz);
        #1;
        check("b2b_1", 8'h41, 4'd7, bus_r.data, 8'hFE);
        drive(8'h30, 4'd5);
        #1;
        check("b2b_hold", 8'h30, 4'd5, bus_r.data, 8'hFE);
        @(posedge clk_50mhz);
        #1;
        check("b2b_2", 8'h30, 4'd5, bus_r.data, 8'hCE);
        drive(8'h20, 4'd7);
        @(posedge clk_50mhz);
        #1;
        check("b2b_3", 8'h20, 4'd7, bus_r.data, 8'h00);

        // Mid-stream reset between edges
        @(negedge clk_50mhz);
        drive(8'h41, 4'd7);
        @(posedge clk_50mhz);
        #1;
        check("pre_midreset", 8'h41, 4'd7, bus_r.data, 8'hFE);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_async", 8'h41, 4'd7, bus_r.data, 8'h00);
        check("midreset_comb", 8'h41, 4'd7, bus_c.data, 8'hFE);
        @(posedge clk_50mhz);
        #1;
        check("midreset_hold", 8'h41, 4'd7, bus_r.data, 8'h00);
        @(negedge clk_50mhz);
        reset_n = 1'b1;
        @(posedge clk_50mhz);
        #1;
        check("post_midreset", 8'h41, 4'd7, bus_r.data, 8'hFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
